// File: rtl/lenet_result_collector.sv
// Collects one frame of N_CLASS signed scores, tracks the running argmax and
// presents {class, score} on a valid/ready port. Optional abort: COLLECTOR_TIMEOUT_EN.
module lenet_result_collector #(
  parameter int DWIDTH      = 16,
  parameter int N_CLASS     = 10,
  parameter int IDX_W       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DWIDTH-1:0] dout,
  input  logic                     dout_st,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [IDX_W-1:0]         res_class,
  output logic signed [DWIDTH-1:0] res_score,
  input  logic [IDX_W-1:0]         rd_addr,
  output logic signed [DWIDTH-1:0] rd_data,
  output logic [15:0]              frame_cnt,
  output logic                     overflow,
  output logic                     err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

  localparam logic [IDX_W-1:0] LP_LAST   = IDX_W'(N_CLASS - 1);
  localparam logic [IDX_W:0]   LP_NCLASS = (IDX_W + 1)'(N_CLASS);

  state_t                     r_state;
  logic [IDX_W-1:0]           r_idx;
  logic signed [DWIDTH-1:0]   r_buf [N_CLASS];
  logic signed [DWIDTH-1:0]   r_max;
  logic [IDX_W-1:0]           r_arg;
  logic                       r_res_valid;
  logic [IDX_W-1:0]           r_res_class;
  logic signed [DWIDTH-1:0]   r_res_score;
  logic [15:0]                r_frame_cnt;
  logic                       r_overflow;

  logic                       w_start;
  logic                       w_take;
  logic                       w_gt;
  logic                       w_last;
  logic signed [DWIDTH-1:0]   w_new_max;
  logic [IDX_W-1:0]           w_new_arg;
  logic                       w_timeout;

  // A new frame opens from IDLE, or from HOLD when the held result is consumed
  // in the same cycle as the first score of the next frame.
  assign w_start   = dout_st && ((r_state == S_IDLE) || ((r_state == S_HOLD) && res_ready));
  assign w_take    = dout_st && (r_state == S_COLLECT);
  assign w_gt      = dout > r_max;
  assign w_last    = (r_idx == LP_LAST);
  assign w_new_max = w_gt ? dout : r_max;
  assign w_new_arg = w_gt ? r_idx : r_arg;

`ifdef COLLECTOR_TIMEOUT_EN
  localparam int LP_TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [LP_TO_W-1:0] LP_TO_LAST = LP_TO_W'(TIMEOUT_CYC - 1);

  logic [LP_TO_W-1:0] r_idle;
  logic               r_err_timeout;

  assign w_timeout = (r_state == S_COLLECT) && !dout_st && (r_idle == LP_TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle        <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_timeout;
      if (dout_st || (r_state != S_COLLECT) || w_timeout) r_idle <= '0;
      else                                                 r_idle <= r_idle + LP_TO_W'(1);
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CLASS; i++) r_buf[i] <= '0;
    end else if (w_start) begin
      r_buf[0] <= dout;
    end else if (w_take) begin
      r_buf[r_idx] <= dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_max       <= '0;
      r_arg       <= '0;
      r_res_valid <= 1'b0;
      r_res_class <= '0;
      r_res_score <= '0;
      r_frame_cnt <= '0;
      r_overflow  <= 1'b0;
    end else if (w_start) begin
      r_max <= dout;
      r_arg <= '0;
      if (N_CLASS == 1) begin
        r_state     <= S_HOLD;
        r_idx       <= '0;
        r_res_valid <= 1'b1;
        r_res_class <= '0;
        r_res_score <= dout;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
        r_state     <= S_COLLECT;
        r_idx       <= IDX_W'(1);
        r_res_valid <= 1'b0;
      end
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (dout_st) begin
            r_max <= w_new_max;
            r_arg <= w_new_arg;
            if (w_last) begin
              r_state     <= S_HOLD;
              r_idx       <= '0;
              r_res_valid <= 1'b1;
              r_res_class <= w_new_arg;
              r_res_score <= w_new_max;
              r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else if (dout_st) begin
            r_overflow <= 1'b1;
          end
        end
        S_IDLE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_data   = ({1'b0, rd_addr} < LP_NCLASS) ? r_buf[rd_addr] : '0;
  assign res_valid = r_res_valid;
  assign res_class = r_res_class;
  assign res_score = r_res_score;
  assign frame_cnt = r_frame_cnt;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_lenet_result_collector.sv
// Self-checking bench for lenet_result_collector: directed frames plus random
// frames checked against an argmax reference model.
module tb_lenet_result_collector;
  localparam int DW = 16;
  localparam int NC = 10;
  localparam int IW = 4;

  typedef logic signed [DW-1:0] score_t;

  logic          clk = 1'b0;
  logic          rst_n;
  score_t        dout;
  logic          dout_st;
  logic          res_valid;
  logic          res_ready;
  logic [IW-1:0] res_class;
  score_t        res_score;
  logic [IW-1:0] rd_addr;
  score_t        rd_data;
  logic [15:0]   frame_cnt;
  logic          overflow;
  logic          err_timeout;

  int            checks = 0;
  int            failures = 0;
  logic [15:0]   exp_frames = '0;
  score_t        frame [NC];
  int            exp_cls;
  score_t        exp_max;

  lenet_result_collector #(
    .DWIDTH(DW), .N_CLASS(NC), .IDX_W(IW), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dout(dout), .dout_st(dout_st),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .res_score(res_score), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_cnt(frame_cnt), .overflow(overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input score_t v);
    dout    = v;
    dout_st = 1'b1;
    tick();
    dout_st = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input int gap);
    for (int i = lo; i <= hi; i++) begin
      send(frame[i]);
      if (i < hi) repeat (gap) tick();
    end
  endtask

  // Reference: the maximum value of the frame, then the first index holding it.
  task automatic ref_argmax();
    int mx;
    mx = int'(frame[0]);
    for (int i = 1; i < NC; i++) if (int'(frame[i]) > mx) mx = int'(frame[i]);
    exp_cls = -1;
    for (int i = NC - 1; i >= 0; i--) if (int'(frame[i]) == mx) exp_cls = i;
    exp_max = score_t'(mx);
  endtask

  task automatic load_ref();
    frame = '{16'sd3, -16'sd5, 16'sd7, 16'sd0, 16'sd7, 16'sd1, 16'sd2, -16'sd1, 16'sd4, 16'sd6};
  endtask

  task automatic rand_frame();
    int t;
    for (int i = 0; i < NC; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        t = $urandom_range(0, 4);
        frame[i] = score_t'(t - 2);
      end else begin
        frame[i] = score_t'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dout = '0; dout_st = 1'b0; res_ready = 1'b0; rd_addr = '0;
    repeat (3) tick();
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", res_valid); end
    checks++; if (res_class !== '0) begin failures++; $display("FAIL reset_class got %0d exp 0", res_class); end
    checks++; if (res_score !== '0) begin failures++; $display("FAIL reset_score got %0d exp 0", res_score); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err_timeout got %b exp 0", err_timeout); end
    for (int a = 0; a < 16; a++) begin
      rd_addr = IW'(a); #1;
      checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_buf[%0d] got %0d exp 0", a, rd_data); end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    res_ready = 1'b1;
    load_ref(); ref_argmax();
    send_range(0, NC - 1, 0);
    exp_frames++;
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got %b exp 1", res_valid); end
    checks++; if (res_class !== IW'(exp_cls) || exp_cls != 2) begin failures++; $display("FAIL basic_class got %0d exp 2", res_class); end
    checks++; if (res_score !== exp_max || exp_max != 16'sd7) begin failures++; $display("FAIL basic_score got %0d exp 7", $signed(res_score)); end
    checks++; if (frame_cnt !== exp_frames) begin failures++; $display("FAIL basic_frame_cnt got %0d exp %0d", frame_cnt, exp_frames); end
    tick();
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got %b exp 0", res_valid); end
    checks++; if (res_class !== 4'd2 || res_score !== 16'sd7) begin failures++; $display("FAIL basic_keep got %0d/%0d exp 2/7", res_class, $signed(res_score)); end
    for (int a = 0; a < 16; a++) begin
      rd_addr = IW'(a); #1;
      checks++;
      if (rd_data !== ((a < NC) ? frame[a] : score_t'(0))) begin
        failures++; $display("FAIL basic_rd[%0d] got %0d exp %0d", a, $signed(rd_data), (a < NC) ? frame[a] : score_t'(0));
      end
    end
  endtask

  task automatic test_signed_min();
    res_ready = 1'b1;
    for (int i = 0; i < NC; i++) frame[i] = 16'sh8000;
    send_range(0, NC - 1, 0);
    exp_frames++;
    checks++; if (res_valid !== 1'b1 || res_class !== 4'd0 || res_score !== 16'sh8000) begin
      failures++; $display("FAIL min_all got v=%b %0d/%h exp 1 0/8000", res_valid, res_class, res_score); end
    tick();
    for (int i = 0; i < NC; i++) frame[i] = 16'sh8000;
    frame[4] = 16'sh7FFF; frame[7] = 16'sh7FFF;
    send_range(0, NC - 1, 0);
    exp_frames++;
    checks++; if (res_class !== 4'd4 || res_score !== 16'sh7FFF) begin
      failures++; $display("FAIL signed_tie got %0d/%h exp 4/7fff", res_class, res_score); end
    checks++; if (frame_cnt !== exp_frames) begin failures++; $display("FAIL min_frame_cnt got %0d exp %0d", frame_cnt, exp_frames); end
    tick();
  endtask

  task automatic test_gaps();
    bit early = 0, err = 0;
    res_ready = 1'b1;
    load_ref(); ref_argmax();
    for (int i = 0; i < NC; i++) begin
      send(frame[i]);
      if (i < NC - 1) begin
        if (res_valid) early = 1;
        repeat (3) begin tick(); if (res_valid) early = 1; if (err_timeout) err = 1; end
      end
    end
    exp_frames++;
    checks++; if (early) begin failures++; $display("FAIL gaps_early_valid got 1 exp 0"); end
    checks++; if (err) begin failures++; $display("FAIL gaps_err_timeout got 1 exp 0"); end
    checks++; if (res_valid !== 1'b1 || res_class !== IW'(exp_cls) || res_score !== exp_max) begin
      failures++; $display("FAIL gaps_result got v=%b %0d/%0d exp 1 %0d/%0d", res_valid, res_class, $signed(res_score), exp_cls, exp_max); end
    tick();
    for (int a = 0; a < NC; a++) begin
      rd_addr = IW'(a); #1;
      checks++; if (rd_data !== frame[a]) begin failures++; $display("FAIL gaps_rd[%0d] got %0d exp %0d", a, $signed(rd_data), frame[a]); end
    end
  endtask

  task automatic test_overflow();
    res_ready = 1'b0;
    load_ref();
    send_range(0, NC - 1, 0);
    exp_frames++;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_before got %b exp 0", overflow); end
    send(16'sd100);
    send(-16'sd200);
    tick();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got %b exp 1", overflow); end
    checks++; if (res_valid !== 1'b1 || res_class !== 4'd2 || res_score !== 16'sd7) begin
      failures++; $display("FAIL ovf_hold got v=%b %0d/%0d exp 1 2/7", res_valid, res_class, $signed(res_score)); end
    rd_addr = '0; #1;
    checks++; if (rd_data !== 16'sd3) begin failures++; $display("FAIL ovf_buf0 got %0d exp 3", $signed(rd_data)); end
    checks++; if (frame_cnt !== exp_frames) begin failures++; $display("FAIL ovf_frame_cnt got %0d exp %0d", frame_cnt, exp_frames); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL ovf_release got %b exp 0", res_valid); end
    tick();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b0;
    load_ref();
    send_range(0, NC - 1, 0);
    exp_frames++;
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got %b exp 1", res_valid); end
    rand_frame();
    frame[0] = 16'sd9;
    ref_argmax();
    res_ready = 1'b1;
    send(16'sd9);
    res_ready = 1'b0;
    rd_addr = '0; #1;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL b2b_transfer got %b exp 0", res_valid); end
    checks++; if (rd_data !== 16'sd9) begin failures++; $display("FAIL b2b_idx0 got %0d exp 9", $signed(rd_data)); end
    send_range(1, NC - 1, 1);
    exp_frames++;
    checks++; if (res_valid !== 1'b1 || res_class !== IW'(exp_cls) || res_score !== exp_max) begin
      failures++; $display("FAIL b2b_result got v=%b %0d/%0d exp 1 %0d/%0d", res_valid, res_class, $signed(res_score), exp_cls, exp_max); end
    checks++; if (frame_cnt !== exp_frames) begin failures++; $display("FAIL b2b_frame_cnt got %0d exp %0d", frame_cnt, exp_frames); end
    res_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int a;
    res_ready = 1'b1;
    for (int f = 0; f < 16; f++) begin
      rand_frame(); ref_argmax();
      send_range(0, NC - 1, $urandom_range(0, 2));
      exp_frames++;
      checks++; if (res_valid !== 1'b1 || res_class !== IW'(exp_cls) || res_score !== exp_max) begin
        failures++; $display("FAIL rand%0d_result got v=%b %0d/%0d exp 1 %0d/%0d", f, res_valid, res_class, $signed(res_score), exp_cls, exp_max); end
      checks++; if (frame_cnt !== exp_frames) begin failures++; $display("FAIL rand%0d_frame_cnt got %0d exp %0d", f, frame_cnt, exp_frames); end
      tick();
      a = $urandom_range(0, NC - 1);
      rd_addr = IW'(a); #1;
      checks++; if (rd_data !== frame[a]) begin failures++; $display("FAIL rand%0d_rd[%0d] got %0d exp %0d", f, a, $signed(rd_data), frame[a]); end
    end
  endtask

  task automatic test_timeout();
    int hit = 0, pulses = 0;
    res_ready = 1'b1;
    rand_frame();
    send_range(0, 3, 0);
`ifdef COLLECTOR_TIMEOUT_EN
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (err_timeout) begin pulses++; if (hit == 0) hit = k; end
    end
    checks++; if (hit != 16) begin failures++; $display("FAIL timeout_cycle got %0d exp 16", hit); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL timeout_pulses got %0d exp 1", pulses); end
    checks++; if (res_valid !== 1'b0 || frame_cnt !== exp_frames) begin
      failures++; $display("FAIL timeout_state got v=%b cnt=%0d exp 0 %0d", res_valid, frame_cnt, exp_frames); end
    rand_frame();
    send_range(0, NC - 1, 0);
`else
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (err_timeout) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL no_timeout_pulses got %0d exp 0", pulses); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL no_timeout_valid got %b exp 0", res_valid); end
    send_range(4, NC - 1, 0);
`endif
    ref_argmax();
    exp_frames++;
    checks++; if (res_valid !== 1'b1 || res_class !== IW'(exp_cls) || res_score !== exp_max) begin
      failures++; $display("FAIL timeout_frame got v=%b %0d/%0d exp 1 %0d/%0d", res_valid, res_class, $signed(res_score), exp_cls, exp_max); end
    checks++; if (frame_cnt !== exp_frames) begin failures++; $display("FAIL timeout_frame_cnt got %0d exp %0d", frame_cnt, exp_frames); end
    tick();
  endtask

  task automatic test_reset_midframe();
    res_ready = 1'b1;
    rand_frame();
    for (int i = 0; i < NC; i++) if (frame[i] == 0) frame[i] = 16'sd1;
    send_range(0, 3, 0);
    rst_n = 1'b0;
    tick();
    rd_addr = '0; #1;
    checks++; if (overflow !== 1'b0 || frame_cnt !== 16'd0 || rd_data !== '0) begin
      failures++; $display("FAIL midreset got ovf=%b cnt=%0d buf0=%0d exp 0 0 0", overflow, frame_cnt, $signed(rd_data)); end
    rst_n = 1'b1;
    tick();
    exp_frames = 16'd1;
    rand_frame(); ref_argmax();
    send_range(0, NC - 1, 0);
    checks++; if (res_valid !== 1'b1 || res_class !== IW'(exp_cls) || res_score !== exp_max) begin
      failures++; $display("FAIL midreset_frame got v=%b %0d/%0d exp 1 %0d/%0d", res_valid, res_class, $signed(res_score), exp_cls, exp_max); end
    checks++; if (frame_cnt !== exp_frames) begin failures++; $display("FAIL midreset_frame_cnt got %0d exp %0d", frame_cnt, exp_frames); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_min();
    test_gaps();
    test_overflow();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
